// File: rtl/frame_window_pkg.sv
// frame_window_pkg: FSM states, default frame geometry and the Hamming coefficient
// generator used to fill the window ROM at elaboration.
package frame_window_pkg;

   localparam int DEF_BWIDTH   = 16;
   localparam int DEF_CWIDTH   = 16;
   localparam int DEF_AWIDTH   = 9;
   localparam int DEF_SEG_SIZE = 420;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

   // round((2^(cw-1)-1) * (0.54 - 0.46*cos(2*pi*i/(n-1)))), always positive
   function automatic int hamming_coef(int i, int cw, int n);
      real a;
      a = 2.0 * 3.141592653589793 * real'(i) / real'(n - 1);
      return $rtoi((2.0 ** (cw - 1) - 1.0) * (0.54 - 0.46 * $cos(a)) + 0.5);
   endfunction

endpackage

// File: rtl/frame_window_rom.sv
// window_rom: synchronous single-read Hamming coefficient ROM, contents computed at elaboration.
module window_rom
   import frame_window_pkg::*;
#(
   parameter int CWIDTH   = DEF_CWIDTH,
   parameter int AWIDTH   = DEF_AWIDTH,
   parameter int SEG_SIZE = DEF_SEG_SIZE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] addr,
   output logic [CWIDTH-1:0] w
);

   logic [CWIDTH-1:0] rom [SEG_SIZE];

   for (genvar i = 0; i < SEG_SIZE; i++) begin : g
      localparam logic [CWIDTH-1:0] C = CWIDTH'(hamming_coef(i, CWIDTH, SEG_SIZE));
      assign rom[i] = C;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) w <= '0;
      else        w <= int'(addr) < SEG_SIZE ? rom[addr] : '0;

endmodule

// File: rtl/frame_window.sv
// frame_window: Hamming-windows the segment stream (3-stage pipeline, II=1) and reports
// per-frame energy with a length-mismatch flag.
module frame_window
   import frame_window_pkg::*;
#(
   parameter int BWIDTH   = DEF_BWIDTH,
   parameter int CWIDTH   = DEF_CWIDTH,
   parameter int AWIDTH   = DEF_AWIDTH,
   parameter int SEG_SIZE = DEF_SEG_SIZE,
   parameter int EWIDTH   = 2 * BWIDTH + AWIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BWIDTH-1:0] x_i,
   input  logic              load,
   input  logic              seg_start,
   input  logic              seg_done,
   output logic [BWIDTH-1:0] y_o,
   output logic              y_valid,
   output logic [EWIDTH-1:0] e_o,
   output logic              e_valid,
   output logic              len_err,
   output logic              busy
);

   localparam int PW = BWIDTH + CWIDTH + 1;
   localparam logic [AWIDTH-1:0]   LAST = AWIDTH'(SEG_SIZE);
   localparam logic signed [PW-1:0] HALF = PW'(1) <<< (CWIDTH - 2);
   localparam logic signed [PW-1:0] YMAX = PW'(2 ** (BWIDTH - 1) - 1);
   localparam logic signed [PW-1:0] YMIN = -YMAX - PW'(1);

   state_t state, nxt;
   logic [AWIDTH-1:0] idx, a1;
   logic [BWIDTH-1:0] x1, x2, ys;
   logic [CWIDTH-1:0] w;
   logic [EWIDTH-1:0] acc;
   logic signed [PW-1:0] p, r;
   logic signed [2*BWIDTH-1:0] ye;
   logic [2*BWIDTH-1:0] sq;
   logic v1, v2, ovf, restart, start_d;
   logic rise, accept, drop, empty, clear;

   window_rom #(.CWIDTH(CWIDTH), .AWIDTH(AWIDTH), .SEG_SIZE(SEG_SIZE)) u_rom (
      .clk(clk), .reset(reset), .addr(a1), .w(w)
   );

   assign rise   = seg_start & ~start_d;
   assign accept = state == RUN && load && idx < LAST;
   assign drop   = state == RUN && load && idx >= LAST;
   assign empty  = !(v1 | v2 | y_valid);
   assign clear  = (state == IDLE && rise) || (state == REPORT && restart);
   assign busy   = state == RUN || state == DRAIN;

   // coefficient is unsigned, so it is zero-extended before the signed multiply
   assign p  = $signed({{(CWIDTH + 1){x2[BWIDTH-1]}}, x2}) * $signed({{(BWIDTH + 1){1'b0}}, w});
   assign r  = (p + HALF) >>> (CWIDTH - 1);
   assign ys = r > YMAX ? YMAX[BWIDTH-1:0] : r < YMIN ? YMIN[BWIDTH-1:0] : r[BWIDTH-1:0];
   assign ye = {{BWIDTH{y_o[BWIDTH-1]}}, y_o};
   assign sq = ye * ye;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = rise ? RUN : IDLE;
         RUN:     nxt = (rise || seg_done) ? DRAIN : RUN;
         DRAIN:   nxt = empty ? REPORT : DRAIN;
         REPORT:  nxt = restart ? RUN : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= IDLE;
         start_d <= 1'b0;
         idx     <= '0;
         a1      <= '0;
         x1      <= '0;
         x2      <= '0;
         v1      <= 1'b0;
         v2      <= 1'b0;
         y_o     <= '0;
         y_valid <= 1'b0;
         acc     <= '0;
         ovf     <= 1'b0;
         restart <= 1'b0;
         e_o     <= '0;
         e_valid <= 1'b0;
         len_err <= 1'b0;
      end else begin
         state   <= nxt;
         start_d <= seg_start;
         a1      <= idx;
         x1      <= x_i;
         v1      <= accept;
         x2      <= x1;
         v2      <= v1;
         y_valid <= v2;
         y_o     <= v2 ? ys : y_o;
         idx     <= clear ? '0 : accept ? idx + 1'b1 : idx;
         acc     <= clear ? '0 : y_valid ? acc + EWIDTH'(sq) : acc;
         ovf     <= state == REPORT ? 1'b0 : ovf | drop;
         // a new frame starting before seg_done forces an erroneous report first
         restart <= state == REPORT ? 1'b0 : restart | (rise & busy);
         e_valid <= state == REPORT;
         e_o     <= state == REPORT ? acc : e_o;
         len_err <= state == REPORT ? ovf | (idx != LAST) | restart : len_err;
      end

endmodule

// File: tb/tb_frame_window.sv
// tb_frame_window: directed frames against the Hamming window formula, with hand-computed
// spot values for edges, centre and saturation.
module tb_frame_window;

   logic        clk = 0, reset = 0, load = 0, seg_start = 0, seg_done = 0;
   logic [15:0] x_i = '0;
   logic [15:0] y_o;
   logic        y_valid, e_valid, len_err, busy;
   logic [40:0] e_o;

   int          tests = 0, fails = 0, cyc = 0, e_cnt = 0, first_load = 0;
   logic [15:0] xs [0:431];
   logic [15:0] yq [$];
   int          ycyc [$];
   logic [40:0] e_last = '0;
   logic        err_last = 0;

   frame_window dut (
      .clk(clk), .reset(reset), .x_i(x_i), .load(load), .seg_start(seg_start),
      .seg_done(seg_done), .y_o(y_o), .y_valid(y_valid), .e_o(e_o),
      .e_valid(e_valid), .len_err(len_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (y_valid) begin
         yq.push_back(y_o);
         ycyc.push_back(cyc);
      end
      if (e_valid) begin
         e_cnt    <= e_cnt + 1;
         e_last   <= e_o;
         err_last <= len_err;
      end
   end

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int coef(int i);
      return $rtoi(32767.0 * (0.54 - 0.46 * $cos(2.0 * 3.141592653589793 * i / 419.0)) + 0.5);
   endfunction

   function automatic logic [15:0] model_y(logic [15:0] x, int i);
      longint pr, rr;
      logic [15:0] res;
      pr = longint'($signed(x)) * longint'(coef(i));
      rr = (pr + 16384) >>> 15;
      rr = rr > 32767 ? 32767 : rr < -32768 ? -32768 : rr;
      res = rr[15:0];
      return res;
   endfunction

   task automatic fill(logic [15:0] v);
      for (int i = 0; i < 432; i++) xs[i] = v;
   endtask

   task automatic flush();
      yq.delete();
      ycyc.delete();
   endtask

   task automatic loads(int n, int gap);
      for (int i = 0; i < n; i++) begin
         if (gap > 0 && i > 0 && i % gap == 0) begin
            @(negedge clk) load = 0;
         end
         @(negedge clk) load = 1;
         x_i = xs[i];
         if (i == 0) first_load = cyc;
      end
   endtask

   task automatic finish_frame(bit coincide);
      if (coincide) seg_done = 1;
      else begin
         @(negedge clk) load = 0;
         seg_done = 1;
      end
      @(negedge clk) load = 0;
      seg_done = 0;
      seg_start = 0;
   endtask

   task automatic send(int n, int gap, bit coincide);
      @(negedge clk) seg_start = 1;
      loads(n - 1, gap);
      if (n > 0) begin
         if (gap > 0 && n - 1 > 0 && (n - 1) % gap == 0) begin
            @(negedge clk) load = 0;
         end
         @(negedge clk) load = 1;
         x_i = xs[n - 1];
         if (n == 1) first_load = cyc;
      end
      finish_frame(coincide);
   endtask

   task automatic wait_report(string tag, int base);
      int k = 0;
      while (e_cnt == base && k < 40) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk({tag, "_report_seen"}, e_cnt - base, 1);
   endtask

   task automatic check_frame(string tag, int ny, logic exp_err);
      longint e = 0;
      int bad = 0;
      logic [15:0] m;
      chk({tag, "_ycount"}, yq.size(), ny);
      for (int i = 0; i < ny; i++) begin
         m = model_y(xs[i], i);
         e += longint'($signed(m)) * longint'($signed(m));
         if (i < yq.size() && yq[i] !== m) bad++;
      end
      chk({tag, "_yseq"}, bad, 0);
      chk({tag, "_energy"}, e_last, e);
      chk({tag, "_len_err"}, err_last, exp_err);
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      chk("rst_y_o", y_o, 0);
      chk("rst_y_valid", y_valid, 0);
      chk("rst_e_o", e_o, 0);
      chk("rst_flags", {e_valid, len_err, busy}, 0);
      reset = 1;
      repeat (2) @(negedge clk);

      // 1: contiguous full frame of 0x4000
      fill(16'h4000);
      flush();
      base = e_cnt;
      send(420, 0, 0);
      chk("t1_busy_drain", busy, 1);
      wait_report("t1", base);
      chk("t1_latency", ycyc.size() > 0 ? ycyc[0] - first_load : -1, 3);
      chk("t1_y_first", yq.size() > 0 ? yq[0] : 16'hxxxx, 16'h051F);
      chk("t1_y_last", yq.size() > 419 ? yq[419] : 16'hxxxx, 16'h051F);
      chk("t1_y_centre", yq.size() > 209 ? yq[209] : 16'hxxxx, 16'h4000);
      check_frame("t1", 420, 0);
      chk("t1_busy_after", busy, 0);

      // 2: same frame with a one-cycle stall every 50 samples
      flush();
      base = e_cnt;
      send(420, 50, 0);
      wait_report("t2", base);
      check_frame("t2", 420, 0);

      // 3: extremes at the two centre indices where w = 0x7FFF
      fill(16'h0000);
      xs[209] = 16'h8000;
      xs[210] = 16'h7FFF;
      flush();
      base = e_cnt;
      send(420, 0, 0);
      wait_report("t3", base);
      chk("t3_neg_full", yq.size() > 209 ? yq[209] : 16'hxxxx, 16'h8001);
      chk("t3_pos_full", yq.size() > 210 ? yq[210] : 16'hxxxx, 16'h7FFE);
      chk("t3_energy_hand", e_last, 64'd2147287045);
      check_frame("t3", 420, 0);

      // 4: short frame, then overlong frame
      fill(16'h4000);
      flush();
      base = e_cnt;
      send(419, 0, 0);
      wait_report("t4s", base);
      check_frame("t4s", 419, 1);
      flush();
      base = e_cnt;
      send(421, 0, 0);
      wait_report("t4l", base);
      check_frame("t4l", 420, 1);

      // 5: reset pulse mid-frame abandons it
      flush();
      base = e_cnt;
      @(negedge clk) seg_start = 1;
      loads(200, 0);
      @(negedge clk) reset = 0;
      load = 0;
      seg_start = 0;
      #1;
      chk("t5_rst_y", {y_o, y_valid}, 0);
      chk("t5_rst_e", {e_o, e_valid, len_err}, 0);
      chk("t5_rst_busy", busy, 0);
      @(negedge clk) reset = 1;
      repeat (12) @(negedge clk);
      chk("t5_no_report", e_cnt - base, 0);
      flush();
      base = e_cnt;
      send(420, 0, 0);
      wait_report("t5", base);
      check_frame("t5", 420, 0);

      // 6: seg_done on the last load, back-to-back frames
      flush();
      base = e_cnt;
      send(420, 0, 1);
      wait_report("t6a", base);
      check_frame("t6a", 420, 0);
      flush();
      base = e_cnt;
      send(420, 0, 1);
      wait_report("t6b", base);
      check_frame("t6b", 420, 0);

      // 7: new seg_start rising edge mid-frame forces an erroneous report, then a new frame
      flush();
      base = e_cnt;
      @(negedge clk) seg_start = 1;
      loads(100, 0);
      @(negedge clk) load = 0;
      seg_start = 0;
      @(negedge clk) seg_start = 1;
      wait_report("t7a", base);
      check_frame("t7a", 100, 1);
      chk("t7_busy_restart", busy, 1);
      flush();
      base = e_cnt;
      loads(420, 0);
      finish_frame(0);
      wait_report("t7b", base);
      check_frame("t7b", 420, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
